// File: rtl/ttt_button_conditioner_pkg.sv
// ============================================================================
// Module      : ttt_button_conditioner_pkg
// Description : Shared types and constants for the tic-tac-toe button conditioner:
//               channel FSM encoding, button indices and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Index order doubles as arbitration priority: higher index wins.
    localparam int BTN_R   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_D   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_C   = 4;
    localparam int NUM_BTN = 5;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_button_conditioner_if.sv
// ============================================================================
// Module      : ttt_button_conditioner_if
// Description : Board-pin and game-engine side signals of the button conditioner.
//               master = pin/engine side, slave = conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ttt_button_conditioner_if;
    import ttt_button_conditioner_pkg::*;

    logic               u_BtnL;
    logic               u_BtnR;
    logic               u_BtnU;
    logic               u_BtnD;
    logic               u_BtnC;
    logic               BtnL;
    logic               BtnR;
    logic               BtnU;
    logic               BtnD;
    logic               BtnC;
    logic [NUM_BTN-1:0] Dpb;

    modport master (
        output u_BtnL, u_BtnR, u_BtnU, u_BtnD, u_BtnC,
        input  BtnL, BtnR, BtnU, BtnD, BtnC, Dpb
    );

    modport slave (
        input  u_BtnL, u_BtnR, u_BtnU, u_BtnD, u_BtnC,
        output BtnL, BtnR, BtnU, BtnD, BtnC, Dpb
    );

endinterface

`default_nettype wire

// File: rtl/ttt_button_conditioner_btn_channel.sv
// ============================================================================
// Module      : ttt_button_conditioner_btn_channel
// Description : One button: 2-flop synchroniser, debounce FSM and counter.
//               Optional auto-repeat under TTT_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_button_conditioner_btn_channel
    import ttt_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef TTT_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000,
    parameter bit REPEAT_EN       = 1'b1
`endif
) (
    input  wire logic Clk,
    input  wire logic reset,
    input  wire logic i_raw,
    output logic      o_strobe,
    output logic      o_level
);

    localparam int             c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    btn_state_t         r_state;
    btn_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_press_strobe;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A drop of the synced input always wins over the terminal count,
    // so a press is accepted only if the last sampled level is still high.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_press_strobe = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt    = ST_HELD;
                    w_press_strobe = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = ST_HELD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_level = (r_state == ST_HELD) || (r_state == ST_RELEASE_WAIT);

`ifdef TTT_AUTOREPEAT_EN
    logic w_rep_fire;

    if (REPEAT_EN) begin : g_repeat
        localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int c_REP_W   = cnt_width(c_REP_MAX);

        logic [c_REP_W-1:0] r_rep_cnt;
        logic               r_rep_first;

        assign w_rep_fire = (r_state == ST_HELD) && r_sync2 &&
                            (r_rep_first ? (r_rep_cnt == c_REP_W'(REPEAT_DELAY - 1))
                                         : (r_rep_cnt == c_REP_W'(REPEAT_PERIOD - 1)));

        // Held at zero outside a stable HELD, so a bounce restarts the delay.
        always_ff @(posedge Clk or posedge reset) begin
            if (reset) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if ((r_state != ST_HELD) || !r_sync2) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
            end else if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt   <= r_rep_cnt + c_REP_W'(1);
            end
        end
    end else begin : g_no_repeat
        assign w_rep_fire = 1'b0;
    end

    assign o_strobe = w_press_strobe | w_rep_fire;
`else
    assign o_strobe = w_press_strobe;
`endif

endmodule

`default_nettype wire

// File: rtl/ttt_button_conditioner.sv
// ============================================================================
// Module      : ttt_button_conditioner
// Description : Five debounced button channels, single-winner arbiter and
//               registered one-cycle strobes. TTT_AUTOREPEAT_EN adds auto-repeat
//               (and its REPEAT_* parameters) to L/R/U/D.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_button_conditioner
    import ttt_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef TTT_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
`endif
) (
    input  wire logic               Clk,
    input  wire logic               reset,
    ttt_button_conditioner_if.slave btn_if
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_raw_strobe;
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_grant;
    logic [NUM_BTN-1:0] r_strobe;

    assign w_raw[BTN_R] = btn_if.u_BtnR;
    assign w_raw[BTN_L] = btn_if.u_BtnL;
    assign w_raw[BTN_D] = btn_if.u_BtnD;
    assign w_raw[BTN_U] = btn_if.u_BtnU;
    assign w_raw[BTN_C] = btn_if.u_BtnC;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_channel
        ttt_button_conditioner_btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef TTT_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (gi != BTN_C)
`endif
        ) u_channel (
            .Clk      (Clk),
            .reset    (reset),
            .i_raw    (w_raw[gi]),
            .o_strobe (w_raw_strobe[gi]),
            .o_level  (w_level[gi])
        );
    end

    // Ascending scan: the highest pending index (C > U > D > L > R) overwrites
    // lower ones, so exactly one grant survives and losers are dropped.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_raw_strobe[i]) begin
                w_grant = NUM_BTN'(1) << i;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_grant;
        end
    end

    assign btn_if.BtnR = r_strobe[BTN_R];
    assign btn_if.BtnL = r_strobe[BTN_L];
    assign btn_if.BtnD = r_strobe[BTN_D];
    assign btn_if.BtnU = r_strobe[BTN_U];
    assign btn_if.BtnC = r_strobe[BTN_C];
    assign btn_if.Dpb  = w_level;

endmodule

`default_nettype wire

// File: tb/tb_ttt_button_conditioner.sv
// ============================================================================
// Module      : tb_ttt_button_conditioner
// Description : Directed self-checking bench for ttt_button_conditioner with
//               DEBOUNCE_CYCLES=4 (REPEAT_DELAY=10, REPEAT_PERIOD=3 if enabled).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttt_button_conditioner;

    logic Clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   strobe_cnt [5];
    int   base_cnt   [5];
    int   multi_cnt;

    ttt_button_conditioner_if bus ();

    ttt_button_conditioner #(
        .DEBOUNCE_CYCLES (4)
`ifdef TTT_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
`endif
    ) dut (
        .Clk    (Clk),
        .reset  (reset),
        .btn_if (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Strobe tally per button index {C,U,D,L,R} = 4..0, plus simultaneous strobes.
    always @(negedge Clk) begin
        if (bus.BtnR) strobe_cnt[0]++;
        if (bus.BtnL) strobe_cnt[1]++;
        if (bus.BtnD) strobe_cnt[2]++;
        if (bus.BtnU) strobe_cnt[3]++;
        if (bus.BtnC) strobe_cnt[4]++;
        if ((32'(bus.BtnR) + 32'(bus.BtnL) + 32'(bus.BtnD) + 32'(bus.BtnU) + 32'(bus.BtnC)) > 1)
            multi_cnt++;
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) base_cnt[i] = strobe_cnt[i];
    endtask

    task automatic set_raw(input logic [4:0] v);
        bus.u_BtnR = v[0];
        bus.u_BtnL = v[1];
        bus.u_BtnD = v[2];
        bus.u_BtnU = v[3];
        bus.u_BtnC = v[4];
    endtask

    initial begin
        logic       all_dpb;
        logic       any_dpb;
        logic [63:0] mask_got;
        logic [63:0] mask_exp;

        n_checks  = 0;
        n_errors  = 0;
        multi_cnt = 0;
        for (int i = 0; i < 5; i++) strobe_cnt[i] = 0;
        reset = 1'b1;
        set_raw(5'b00000);
        tick(3);
        check_value("reset_dpb", 64'(bus.Dpb), 64'h0);
        check_value("reset_strobes", 64'({bus.BtnC, bus.BtnU, bus.BtnD, bus.BtnL, bus.BtnR}), 64'h0);

        // 1: C held from reset release, strobe exactly at cycle 7
        snap();
        reset = 1'b0;
        set_raw(5'b10000);
        tick(6);
        check_value("t1_btnc_c6", 64'(bus.BtnC), 64'h0);
        tick(1);
        check_value("t1_btnc_c7", 64'(bus.BtnC), 64'h1);
        check_value("t1_dpb_c7", 64'(bus.Dpb), 64'h10);
        tick(1);
        check_value("t1_btnc_c8", 64'(bus.BtnC), 64'h0);
        tick(12);
        check_value("t1_count", 64'(strobe_cnt[4] - base_cnt[4]), 64'd1);
        check_value("t1_dpb_held", 64'(bus.Dpb), 64'h10);
        set_raw(5'b00000);
        tick(10);
        check_value("t1_dpb_released", 64'(bus.Dpb), 64'h0);

        // 2: 3-cycle glitch on L is rejected
        snap();
        set_raw(5'b00010);
        any_dpb = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick(1);
            if (t == 3) set_raw(5'b00000);
            any_dpb = any_dpb | (|bus.Dpb);
        end
        check_value("t2_dpb", 64'(any_dpb), 64'h0);
        check_value("t2_count", 64'(strobe_cnt[1] - base_cnt[1]), 64'd0);

        // 3: L accepted, 2-cycle bounce low shortly after, still one strobe
        snap();
        set_raw(5'b00010);
        tick(7);
        check_value("t3_btnl_c7", 64'(bus.BtnL), 64'h1);
        all_dpb = 1'b1;
        for (int t = 8; t <= 20; t++) begin
            tick(1);
            if (t == 8)  set_raw(5'b00000);
            if (t == 10) set_raw(5'b00010);
            all_dpb = all_dpb & bus.Dpb[1];
        end
        check_value("t3_dpb_hold", 64'(all_dpb), 64'h1);
        check_value("t3_count", 64'(strobe_cnt[1] - base_cnt[1]), 64'd1);
        set_raw(5'b00000);
        tick(10);
        check_value("t3_dpb_released", 64'(bus.Dpb), 64'h0);

        // 4: U and R together, U wins, R dropped, both levels up
        snap();
        set_raw(5'b01001);
        tick(7);
        check_value("t4_strobes_c7", 64'({bus.BtnC, bus.BtnU, bus.BtnD, bus.BtnL, bus.BtnR}), 64'h08);
        tick(8);
        check_value("t4_count_u", 64'(strobe_cnt[3] - base_cnt[3]), 64'd1);
        check_value("t4_count_r", 64'(strobe_cnt[0] - base_cnt[0]), 64'd0);
        check_value("t4_dpb", 64'(bus.Dpb), 64'h09);
        set_raw(5'b00000);
        tick(10);

        // 5: reset during D press-wait, D still held at release
        snap();
        set_raw(5'b00100);
        tick(4);
        reset = 1'b1;
        tick(3);
        check_value("t5_dpb_in_reset", 64'(bus.Dpb), 64'h0);
        check_value("t5_count_pre", 64'(strobe_cnt[2] - base_cnt[2]), 64'd0);
        reset = 1'b0;
        tick(6);
        check_value("t5_btnd_c6", 64'(bus.BtnD), 64'h0);
        tick(1);
        check_value("t5_btnd_c7", 64'(bus.BtnD), 64'h1);
        tick(5);
        check_value("t5_count", 64'(strobe_cnt[2] - base_cnt[2]), 64'd1);
        set_raw(5'b00000);
        tick(10);

`ifdef TTT_AUTOREPEAT_EN
        // 6: R auto-repeat at acceptance, +10, then every 3; C never repeats
        set_raw(5'b00001);
        mask_got = '0;
        mask_exp = '0;
        mask_exp[7] = 1'b1;
        for (int k = 17; k <= 37; k += 3) mask_exp[k] = 1'b1;
        for (int t = 1; t <= 37; t++) begin
            tick(1);
            mask_got[t] = bus.BtnR;
        end
        check_value("t6_repeat_r", mask_got, mask_exp);
        set_raw(5'b00000);
        tick(10);
        snap();
        set_raw(5'b10000);
        tick(40);
        check_value("t6_count_c", 64'(strobe_cnt[4] - base_cnt[4]), 64'd1);
        set_raw(5'b00000);
        tick(10);
`else
        mask_got = '0;
        mask_exp = '0;
        check_value("t6_no_extra_strobes", mask_got | 64'(multi_cnt), mask_exp);
`endif

        check_value("one_strobe_per_cycle", 64'(multi_cnt), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
